// File: rtl/dac8411_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : dac8411_frame_capture
// Description : Receive-side decoder for the DAC8411 SYNC/SCLK/DIN write link.
//               Oversamples the pins on clk and decodes 24-bit frames into
//               {PD1,PD0} and a 16-bit code. It also reports aborted frames and
//               keeps saturating frame and error counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dac8411_frame_capture #(
    parameter int FRAME_BITS  = 24,
    parameter int DAC_WIDTH   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 sclk_in,
    input  logic                 din_in,
    input  logic                 syncn_in,
    output logic [DAC_WIDTH-1:0] data_out,
    output logic [1:0]           pd_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy,
    output logic [15:0]          frame_count,
    output logic [15:0]          error_count
);

    localparam int c_cnt_w    = $clog2(FRAME_BITS + 1);
    localparam int c_data_lsb = FRAME_BITS - 2 - DAC_WIDTH;
    localparam logic [c_cnt_w-1:0] c_frame_bits = c_cnt_w'(FRAME_BITS);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SHIFT     = 2'd1,
        S_WAIT_HIGH = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic [SYNC_STAGES-1:0] r_sync_sync;
    logic                   r_sclk_d;
    logic                   r_sync_d;
    // Marks when r_sync_d holds a genuine pin sample rather than its reset value
    logic [SYNC_STAGES:0]   r_prime;

    logic                   w_sclk_s;
    logic                   w_din_s;
    logic                   w_sync_s;
    logic                   w_sclk_fall;
    logic                   w_sync_fall;
    logic                   w_sync_rise;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [FRAME_BITS-1:0]  r_sr;
    logic [FRAME_BITS-1:0]  w_sr_next;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_cnt_w-1:0]     w_cnt_next;
    logic                   w_valid;
    logic                   w_abort;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_din_s  = r_din_sync[SYNC_STAGES-1];
    assign w_sync_s = r_sync_sync[SYNC_STAGES-1];

    assign w_sclk_fall = r_sclk_d & ~w_sclk_s;
    assign w_sync_rise = ~r_sync_d & w_sync_s;
    // A fall only counts once SYNC has genuinely been seen high after reset,
    // so a pin held low through reset release cannot start a frame.
    assign w_sync_fall = r_prime[SYNC_STAGES] & r_sync_d & ~w_sync_s;

    // Input synchronizers and edge-detect delay registers (idle-high pins)
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_sclk_sync <= '1;
            r_din_sync  <= '1;
            r_sync_sync <= '1;
            r_sclk_d    <= 1'b1;
            r_sync_d    <= 1'b1;
            r_prime     <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], din_in};
            r_sync_sync <= {r_sync_sync[SYNC_STAGES-2:0], syncn_in};
            r_sclk_d    <= w_sclk_s;
            r_sync_d    <= w_sync_s;
            r_prime     <= {r_prime[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, shift/count and completion decode; a coincident SCLK fall
    // is shifted before completion is judged
    always_comb begin
        w_state_next = r_state;
        w_sr_next    = r_sr;
        w_cnt_next   = r_cnt;
        w_valid      = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sync_fall) begin
                    w_sr_next    = '0;
                    w_cnt_next   = '0;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_sclk_fall) begin
                    w_sr_next  = {r_sr[FRAME_BITS-2:0], w_din_s};
                    w_cnt_next = r_cnt + 1'b1;
                end
                if (w_cnt_next == c_frame_bits) begin
                    w_valid      = 1'b1;
                    w_state_next = w_sync_rise ? S_IDLE : S_WAIT_HIGH;
                end else if (w_sync_rise) begin
                    w_abort      = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_HIGH: begin
                if (w_sync_rise) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath, registered outputs and saturating status counters
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            data_out    <= '0;
            pd_out      <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
            error_count <= '0;
        end else begin
            r_sr        <= w_sr_next;
            r_cnt       <= w_cnt_next;
            data_valid  <= w_valid;
            frame_error <= w_abort;
            busy        <= (w_state_next != S_IDLE);
            if (w_valid) begin
                pd_out   <= w_sr_next[FRAME_BITS-1 -: 2];
                data_out <= w_sr_next[c_data_lsb +: DAC_WIDTH];
                if (frame_count != 16'hFFFF) begin
                    frame_count <= frame_count + 16'd1;
                end
            end
            if (w_abort && (error_count != 16'hFFFF)) begin
                error_count <= error_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac8411_frame_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac8411_frame_capture
// Description : Self-checking bench for dac8411_frame_capture. Frames come
//               from a vector table plus hand-written corner sequences. A
//               scoreboard queue holds the expected decoded words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac8411_frame_capture;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        sclk_in = 1'b1;
    logic        din_in = 1'b0;
    logic        syncn_in = 1'b1;
    logic [15:0] data_out;
    logic [1:0]  pd_out;
    logic        data_valid;
    logic        frame_error;
    logic        busy;
    logic [15:0] frame_count;
    logic [15:0] error_count;

    dac8411_frame_capture #(.FRAME_BITS(24), .DAC_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .sclk_in     (sclk_in),
        .din_in      (din_in),
        .syncn_in    (syncn_in),
        .data_out    (data_out),
        .pd_out      (pd_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy),
        .frame_count (frame_count),
        .error_count (error_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] bits;      // wire order, bit 23 first
        int          nbits;     // SCLK falls inside SYNC low
        int          extra;     // extra falls after the 24th
        bit          coinc;     // last fall coincides with SYNC rise
        bit          exp_valid; // frame must decode as valid
    } vec_t;

    vec_t        tbl[10];
    logic [17:0] sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          vld_seen = 0;
    int          err_seen = 0;
    logic [15:0] exp_frames = '0;
    logic [15:0] exp_errs = '0;
    logic [15:0] exp_data = '0;
    logic [1:0]  exp_pd = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every data_valid pulse consumes one expected word
    always @(negedge clk) begin
        if (aresetn) begin
            if (data_valid) begin
                vld_seen++;
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", {14'd0, pd_out, data_out}, 32'hFFFF_FFFF);
                end else begin
                    check("valid_word", {14'd0, pd_out, data_out}, {14'd0, sb_q.pop_front()});
                end
            end
            if (frame_error) err_seen++;
            if (data_valid || frame_error) begin
                check("pulse_exclusive", {31'd0, data_valid & frame_error}, 32'd0);
            end
        end
    end

    task automatic run_frame(input vec_t v);
        if (v.exp_valid) begin
            sb_q.push_back({v.bits[23:22], v.bits[21:6]});
            exp_pd   = v.bits[23:22];
            exp_data = v.bits[21:6];
            if (exp_frames != 16'hFFFF) exp_frames = exp_frames + 16'd1;
        end else if (exp_errs != 16'hFFFF) begin
            exp_errs = exp_errs + 16'd1;
        end
        syncn_in = 1'b0;
        #40;
        for (int i = 0; i < v.nbits; i++) begin
            din_in  = v.bits[23-i];
            sclk_in = 1'b1;
            #40;
            if (v.coinc && (i == v.nbits - 1)) begin
                sclk_in  = 1'b0;
                syncn_in = 1'b1;
                #40;
                sclk_in  = 1'b1;
            end else begin
                sclk_in = 1'b0;
                #40;
            end
        end
        for (int i = 0; i < v.extra; i++) begin
            din_in  = ~din_in;
            sclk_in = 1'b1;
            #40;
            sclk_in = 1'b0;
            #40;
        end
        if (!(v.coinc && v.nbits > 0)) begin
            sclk_in = 1'b1;
            #40;
            syncn_in = 1'b1;
        end
        #200;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_frame_count"}, {16'd0, frame_count}, {16'd0, exp_frames});
        check({tag, "_error_count"}, {16'd0, error_count}, {16'd0, exp_errs});
        check({tag, "_data_out"}, {16'd0, data_out}, {16'd0, exp_data});
        check({tag, "_pd_out"}, {30'd0, pd_out}, {30'd0, exp_pd});
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int e0;
        vec_t v;
        //          bits                                  n   ex co  valid
        tbl[0] = '{{2'b00, 16'hA5C3, 6'b000000},          24, 0, 0, 1};
        tbl[1] = '{{2'b11, 16'h0001, 6'b000000},          24, 0, 0, 1};
        tbl[2] = '{{2'b01, 16'hFFFF, 6'b000000},          24, 0, 0, 1};
        tbl[3] = '{{2'b10, 16'h1234, 6'b110011},          24, 0, 0, 1};
        tbl[4] = '{24'hFFFFFF,                            10, 0, 0, 0};
        tbl[5] = '{{2'b00, 16'h8001, 6'b000000},          24, 2, 0, 1};
        tbl[6] = '{{2'b10, 16'h5A5A, 6'b101010},          24, 0, 1, 1};
        tbl[7] = '{24'h0F0F0F,                            10, 0, 1, 0};
        tbl[8] = '{24'h000000,                             0, 0, 0, 0};
        tbl[9] = '{{2'b01, 16'hC33C, 6'b111111},          23, 0, 0, 0};

        // Reset state
        #20;
        check("rst_data_out", {16'd0, data_out}, 32'd0);
        check("rst_valid", {30'd0, data_valid, frame_error}, 32'd0);
        check("rst_counts", {frame_count, error_count}, 32'd0);
        aresetn = 1'b1;
        #100;
        check_status("post_reset");

        // Table-driven frames
        foreach (tbl[k]) begin
            v0 = vld_seen;
            e0 = err_seen;
            run_frame(tbl[k]);
            check($sformatf("vec%0d_valid_pulses", k), vld_seen - v0, tbl[k].exp_valid ? 1 : 0);
            check($sformatf("vec%0d_error_pulses", k), err_seen - e0, tbl[k].exp_valid ? 0 : 1);
            check_status($sformatf("vec%0d", k));
        end

        // Reset mid-frame, SYNC still low when reset releases
        syncn_in = 1'b0;
        #40;
        for (int i = 0; i < 12; i++) begin
            din_in  = i[0];
            sclk_in = 1'b1;
            #40;
            sclk_in = 1'b0;
            #40;
        end
        check("midframe_busy", {31'd0, busy}, 32'd1);
        aresetn = 1'b0;
        #10;
        check("midrst_data", {14'd0, pd_out, data_out}, 32'd0);
        check("midrst_counts", {frame_count, error_count}, 32'd0);
        check("midrst_flags", {29'd0, data_valid, frame_error, busy}, 32'd0);
        exp_frames = '0;
        exp_errs   = '0;
        exp_data   = '0;
        exp_pd     = '0;
        sclk_in    = 1'b1;
        #20;
        aresetn = 1'b1;
        #100;
        syncn_in = 1'b1;
        #200;
        check_status("low_sync_release");
        v = '{{2'b00, 16'h00FF, 6'b010101}, 24, 0, 0, 1};
        run_frame(v);
        check_status("after_reset_frame");

        // Saturation of the frame counter
        force dut.frame_count = 16'hFFFE;
        #10;
        release dut.frame_count;
        exp_frames = 16'hFFFE;
        v = '{{2'b11, 16'hBEEF, 6'b000000}, 24, 0, 0, 1};
        run_frame(v);
        check_status("sat_frame_1");
        v0 = vld_seen;
        v = '{{2'b01, 16'h0BAD, 6'b000000}, 24, 0, 0, 1};
        run_frame(v);
        check("sat_still_pulses", vld_seen - v0, 1);
        check_status("sat_frame_2");

        // Saturation of the error counter
        force dut.error_count = 16'hFFFF;
        #10;
        release dut.error_count;
        exp_errs = 16'hFFFF;
        e0 = err_seen;
        v = '{24'hAAAAAA, 5, 0, 0, 0};
        run_frame(v);
        check("sat_err_pulse", err_seen - e0, 1);
        check_status("sat_error");

        for (int t = 0; t < 100 && sb_q.size() != 0; t++) #10;
        check("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
